// File: rtl/pc_sequencer.sv
// Program-counter controller for the MIPS fetch path: selects sequential, branch
// or jump targets and holds a fixed-length fetch flush after every redirect.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_req,
    input  logic        branch_cond,
    input  logic [15:0] branch_imm,
    input  logic        jump_req,
    input  logic [25:0] jump_index,
    input  logic        link,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ret_addr,
    output logic        redirect,
    output logic        flush,
    output logic        fetch_valid
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 3;

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  ret_addr_q, ret_addr_d;
    logic             redirect_q, redirect_d;
    logic             flush_q, flush_d;

    logic [XLEN-1:0]  branch_off;
    logic [XLEN-1:0]  jump_tgt;

    assign pc_plus4   = pc_q + XLEN'(4);
    assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jump_tgt   = {pc_plus4[31:28], jump_index, 2'b00};

    // Next-state and next-PC selection; requests only act in RUN without stall.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        ret_addr_d = ret_addr_q;
        redirect_d = 1'b0;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    if (jump_req) begin
                        pc_d       = jump_tgt;
                        redirect_d = 1'b1;
                        state_d    = FLUSH;
                        cnt_d      = CNT_W'(FLUSH_CYCLES);
                        if (link) begin
                            ret_addr_d = pc_plus4;
                        end
                    end else if (branch_req && branch_cond) begin
                        pc_d       = pc_plus4 + branch_off;
                        redirect_d = 1'b1;
                        state_d    = FLUSH;
                        cnt_d      = CNT_W'(FLUSH_CYCLES);
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            FLUSH: begin
                // Counter runs down regardless of stall so flush length is fixed.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        flush_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            ret_addr_q <= '0;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            ret_addr_q <= ret_addr_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
        end
    end

    assign pc          = pc_q;
    assign ret_addr    = ret_addr_q;
    assign redirect    = redirect_q;
    assign flush       = flush_q;
    assign fetch_valid = ~flush_q & ~stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: three instances (default, 3-cycle flush,
// near-top reset PC) checked against a queue of expected post-edge states.
module tb_pc_sequencer;

    logic        clk;
    logic        rst         [3];
    logic        stall       [3];
    logic        branch_req  [3];
    logic        branch_cond [3];
    logic [15:0] branch_imm  [3];
    logic        jump_req    [3];
    logic [25:0] jump_index  [3];
    logic        link        [3];
    logic [31:0] pc          [3];
    logic [31:0] pc_plus4    [3];
    logic [31:0] ret_addr    [3];
    logic        redirect    [3];
    logic        flush       [3];
    logic        fetch_valid [3];

    typedef struct {
        int          dut;
        string       tag;
        logic [31:0] pc;
        logic [31:0] ra;
        logic        red;
        logic        fl;
        logic        fv;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(1)) u_a (
        .clk(clk), .rst(rst[0]), .stall(stall[0]), .branch_req(branch_req[0]),
        .branch_cond(branch_cond[0]), .branch_imm(branch_imm[0]), .jump_req(jump_req[0]),
        .jump_index(jump_index[0]), .link(link[0]), .pc(pc[0]), .pc_plus4(pc_plus4[0]),
        .ret_addr(ret_addr[0]), .redirect(redirect[0]), .flush(flush[0]),
        .fetch_valid(fetch_valid[0])
    );

    pc_sequencer #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(3)) u_b (
        .clk(clk), .rst(rst[1]), .stall(stall[1]), .branch_req(branch_req[1]),
        .branch_cond(branch_cond[1]), .branch_imm(branch_imm[1]), .jump_req(jump_req[1]),
        .jump_index(jump_index[1]), .link(link[1]), .pc(pc[1]), .pc_plus4(pc_plus4[1]),
        .ret_addr(ret_addr[1]), .redirect(redirect[1]), .flush(flush[1]),
        .fetch_valid(fetch_valid[1])
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFF8), .FLUSH_CYCLES(1)) u_c (
        .clk(clk), .rst(rst[2]), .stall(stall[2]), .branch_req(branch_req[2]),
        .branch_cond(branch_cond[2]), .branch_imm(branch_imm[2]), .jump_req(jump_req[2]),
        .jump_index(jump_index[2]), .link(link[2]), .pc(pc[2]), .pc_plus4(pc_plus4[2]),
        .ret_addr(ret_addr[2]), .redirect(redirect[2]), .flush(flush[2]),
        .fetch_valid(fetch_valid[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input string tag, input logic [31:0] p,
                        input logic [31:0] ra, input logic red, input logic fl,
                        input logic fv);
        exp_t e;
        e.dut = d; e.tag = tag; e.pc = p; e.ra = ra;
        e.red = red; e.fl = fl; e.fv = fv;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".pc"},    pc[e.dut],       e.pc);
            cmp({e.tag, ".pc4"},   pc_plus4[e.dut], e.pc + 32'd4);
            cmp({e.tag, ".ra"},    ret_addr[e.dut], e.ra);
            cmp({e.tag, ".redir"}, 32'(redirect[e.dut]),    32'(e.red));
            cmp({e.tag, ".flush"}, 32'(flush[e.dut]),       32'(e.fl));
            cmp({e.tag, ".fv"},    32'(fetch_valid[e.dut]), 32'(e.fv));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic clear_req(input int d);
        branch_req[d] = 1'b0; branch_cond[d] = 1'b0; branch_imm[d] = '0;
        jump_req[d] = 1'b0; jump_index[d] = '0; link[d] = 1'b0;
    endtask

    task automatic reset_dut(input int d, input logic [31:0] rpc);
        rst[d] = 1'b1;
        #1;
        push(d, "rst", rpc, 32'h0, 1'b0, 1'b0, 1'b1);
        drain();
        rst[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            stall[i] = 1'b0;
            clear_req(i);
        end
        #2;
        push(0, "por_a", 32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b1);
        push(1, "por_b", 32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b1);
        push(2, "por_c", 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0, 1'b1);
        drain();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Wrap-around near the top of the address space.
        reset_dut(2, 32'hFFFF_FFF8);
        push(2, "wrap0", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        push(2, "wrap1", 32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        branch_req[2] = 1'b1; branch_cond[2] = 1'b1; branch_imm[2] = 16'h8000;
        push(2, "bwrap", 32'hFFFE_0004, 32'h0, 1'b1, 1'b1, 1'b0); tick();
        clear_req(2);
        push(2, "bwrap_run", 32'hFFFE_0004, 32'h0, 1'b0, 1'b0, 1'b1); tick();

        // Free run, taken branch back, not-taken branch.
        reset_dut(0, 32'h0);
        push(0, "seq4", 32'h4, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        push(0, "seq8", 32'h8, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        push(0, "seqC", 32'hC, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        push(0, "seq10", 32'h10, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        branch_req[0] = 1'b1; branch_cond[0] = 1'b1; branch_imm[0] = 16'hFFFC;
        push(0, "br_taken", 32'h4, 32'h0, 1'b1, 1'b1, 1'b0); tick();
        clear_req(0);
        push(0, "br_flush_end", 32'h4, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        push(0, "br_resume", 32'h8, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        push(0, "seqC_2", 32'hC, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        push(0, "seq10_2", 32'h10, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        branch_req[0] = 1'b1; branch_cond[0] = 1'b0; branch_imm[0] = 16'hFFFC;
        push(0, "br_not", 32'h14, 32'h0, 1'b0, 1'b0, 1'b1); tick();

        // Plain jump to 0x0040_0020, then JAL with a competing branch.
        clear_req(0);
        jump_req[0] = 1'b1; jump_index[0] = 26'h010_0008;
        push(0, "j", 32'h0040_0020, 32'h0, 1'b1, 1'b1, 1'b0); tick();
        clear_req(0);
        push(0, "j_end", 32'h0040_0020, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        jump_req[0] = 1'b1; jump_index[0] = 26'h10; link[0] = 1'b1;
        branch_req[0] = 1'b1; branch_cond[0] = 1'b1; branch_imm[0] = 16'h0004;
        push(0, "jal", 32'h0000_0040, 32'h0040_0024, 1'b1, 1'b1, 1'b0); tick();
        clear_req(0);
        push(0, "jal_end", 32'h0000_0040, 32'h0040_0024, 1'b0, 1'b0, 1'b1); tick();
        link[0] = 1'b1;
        push(0, "link_only", 32'h0000_0044, 32'h0040_0024, 1'b0, 1'b0, 1'b1); tick();

        // Stall at pc=0x8 blocks a JAL.
        jump_req[0] = 1'b1; jump_index[0] = 26'h2; link[0] = 1'b1;
        push(0, "jal8", 32'h8, 32'h48, 1'b1, 1'b1, 1'b0); tick();
        clear_req(0);
        push(0, "jal8_end", 32'h8, 32'h48, 1'b0, 1'b0, 1'b1); tick();
        stall[0] = 1'b1; jump_req[0] = 1'b1; jump_index[0] = 26'h55; link[0] = 1'b1;
        #1;
        push(0, "stall_now", 32'h8, 32'h48, 1'b0, 1'b0, 1'b0); drain();
        for (int i = 0; i < 3; i++) begin
            push(0, "stall", 32'h8, 32'h48, 1'b0, 1'b0, 1'b0); tick();
        end
        stall[0] = 1'b0;
        clear_req(0);
        push(0, "unstall", 32'hC, 32'h48, 1'b0, 1'b0, 1'b1); tick();

        // Three-cycle flush with stall toggling and an ignored jump.
        reset_dut(1, 32'h0);
        branch_req[1] = 1'b1; branch_cond[1] = 1'b1; branch_imm[1] = 16'h0010;
        push(1, "f3_br", 32'h44, 32'h0, 1'b1, 1'b1, 1'b0); tick();
        clear_req(1);
        stall[1] = 1'b1; jump_req[1] = 1'b1; jump_index[1] = 26'h3FF;
        push(1, "f3_c2", 32'h44, 32'h0, 1'b0, 1'b1, 1'b0); tick();
        stall[1] = 1'b0;
        push(1, "f3_c3", 32'h44, 32'h0, 1'b0, 1'b1, 1'b0); tick();
        stall[1] = 1'b1;
        push(1, "f3_end", 32'h44, 32'h0, 1'b0, 1'b0, 1'b0); tick();
        stall[1] = 1'b0;
        clear_req(1);
        #1;
        push(1, "f3_run", 32'h44, 32'h0, 1'b0, 1'b0, 1'b1); drain();
        push(1, "f3_seq", 32'h48, 32'h0, 1'b0, 1'b0, 1'b1); tick();

        // Asynchronous reset during the second flush cycle.
        branch_req[1] = 1'b1; branch_cond[1] = 1'b1; branch_imm[1] = 16'h0008;
        push(1, "f3_br2", 32'h6C, 32'h0, 1'b1, 1'b1, 1'b0); tick();
        clear_req(1);
        push(1, "f3_br2_c2", 32'h6C, 32'h0, 1'b0, 1'b1, 1'b0); tick();
        rst[1] = 1'b1;
        #2;
        push(1, "mid_rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1); drain();
        #2;
        rst[1] = 1'b0;
        push(1, "post_rst", 32'h4, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        push(1, "post_rst2", 32'h8, 32'h0, 1'b0, 1'b0, 1'b1); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
